// File: rtl/rate_pkg.sv
// Shared definitions for the slow-rate detector: rate codes, FSM encoding and
// the period classifier.
package rate_pkg;

  localparam logic [2:0] RATE_NONE    = 3'd0;
  localparam logic [2:0] RATE_2HZ     = 3'd1;
  localparam logic [2:0] RATE_1HZ     = 3'd2;
  localparam logic [2:0] RATE_05HZ    = 3'd3;
  localparam logic [2:0] RATE_025HZ   = 3'd4;
  localparam logic [2:0] RATE_UNKNOWN = 3'd7;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } state_e;

  // Inclusive window of +/- nominal/tol_div cycles around a nominal period.
  function automatic logic in_window(input logic [63:0]      cnt,
                                     input longint unsigned  nominal,
                                     input longint unsigned  tol_div);
    longint unsigned tol;
    tol = nominal / tol_div;
    return (cnt >= nominal - tol) && (cnt <= nominal + tol);
  endfunction

  function automatic logic [2:0] classify(input logic [63:0]     cnt,
                                          input longint unsigned clk_hz,
                                          input longint unsigned tol_div);
    logic [2:0] code;
    code = RATE_UNKNOWN;
    if (in_window(cnt, clk_hz / 2, tol_div))           code = RATE_2HZ;
    else if (in_window(cnt, clk_hz, tol_div))          code = RATE_1HZ;
    else if (in_window(cnt, clk_hz * 2, tol_div))      code = RATE_05HZ;
    else if (in_window(cnt, clk_hz * 4, tol_div))      code = RATE_025HZ;
    return code;
  endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchroniser for a slow asynchronous input, with a one-cycle pulse
// on each synchronised rising edge.
module sync_rise_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/rate_detector.sv
// Measures the rise-to-rise period of a slow square wave in CLOCK_50 cycles
// and classifies it as one of the divider tick rates.
module rate_detector
  import rate_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned TOL_DIV = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             sig_in,
  output logic [2:0]       rate_code,
  output logic [CNT_W-1:0] period_cycles,
  output logic             valid,
  output logic             rate_change,
  output logic             no_signal
);

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(64'(CLK_HZ) * 64'd8);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= TIMEOUT) ? TIMEOUT : v + CNT_W'(1);
  endfunction

  logic             rise;
  logic [2:0]       cls_w;

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [2:0]       rate_q,   rate_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q,  valid_d;
  logic             rchg_q,   rchg_d;
  logic             nosig_q,  nosig_d;

  sync_rise_detect u_sync (
    .clk_i  (CLOCK_50),
    .rst_i  (reset),
    .d_i    (sig_in),
    .rise_o (rise)
  );

  assign cls_w = classify(64'(cnt_q), 64'(CLK_HZ), 64'(TOL_DIV));

  // The counter always runs; only MEASURE acts on its value, so a rise in
  // WAIT_FIRST simply re-arms it at 1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = rise ? CNT_W'(1) : sat_inc(cnt_q);
    rate_d   = rate_q;
    period_d = period_q;
    valid_d  = 1'b0;
    rchg_d   = 1'b0;
    nosig_d  = nosig_q;
    unique case (state_q)
      WAIT_FIRST: begin
        if (rise) state_d = MEASURE;
      end
      MEASURE: begin
        if (rise) begin
          period_d = cnt_q;
          rate_d   = cls_w;
          valid_d  = 1'b1;
          rchg_d   = (cls_w != rate_q);
          nosig_d  = 1'b0;
        end else if (cnt_q == TIMEOUT) begin
          period_d = '0;
          rate_d   = RATE_NONE;
          nosig_d  = 1'b1;
          state_d  = WAIT_FIRST;
        end
      end
      default: state_d = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= WAIT_FIRST;
      cnt_q    <= '0;
      rate_q   <= RATE_NONE;
      period_q <= '0;
      valid_q  <= 1'b0;
      rchg_q   <= 1'b0;
      nosig_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rate_q   <= rate_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      rchg_q   <= rchg_d;
      nosig_q  <= nosig_d;
    end
  end

  assign rate_code     = rate_q;
  assign period_cycles = period_q;
  assign valid         = valid_q;
  assign rate_change   = rchg_q;
  assign no_signal     = nosig_q;

endmodule

// File: tb/tb_rate_detector.sv
// Directed bench for rate_detector at CLK_HZ=1000: a period table plus
// hand-written sequences for latency, timeout and mid-period reset.
module tb_rate_detector;

  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned TOL_DIV = 64;
  localparam int unsigned CNT_W   = 32;

  logic             CLOCK_50 = 1'b0;
  logic             reset    = 1'b1;
  logic             sig_in   = 1'b0;
  logic [2:0]       rate_code;
  logic [CNT_W-1:0] period_cycles;
  logic             valid;
  logic             rate_change;
  logic             no_signal;

  rate_detector #(.CLK_HZ(CLK_HZ), .TOL_DIV(TOL_DIV), .CNT_W(CNT_W)) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .sig_in        (sig_in),
    .rate_code     (rate_code),
    .period_cycles (period_cycles),
    .valid         (valid),
    .rate_change   (rate_change),
    .no_signal     (no_signal)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int nvec = 0;
  int nerr = 0;

  int         vtot = 0;
  int         spurious = 0;
  logic [2:0] last_code = 3'd0;
  logic [31:0] last_period = 32'd0;
  logic       last_rc = 1'b0;

  always @(negedge CLOCK_50) begin
    if (valid) begin
      vtot        <= vtot + 1;
      last_code   <= rate_code;
      last_period <= period_cycles;
      last_rc     <= rate_change;
    end
    if (rate_change && !valid) spurious <= spurious + 1;
  end

  typedef struct {
    int p;
    int h;
    int code;
    int rc;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_period(input int p, input int h);
    for (int c = 0; c < p; c++) begin
      sig_in = (c < h);
      cyc();
    end
  endtask

  int base;

  initial begin
    tbl[0]  = '{500,  250, 1, 1};
    tbl[1]  = '{500,  250, 1, 0};
    tbl[2]  = '{1000, 500, 2, 1};
    tbl[3]  = '{2000, 1000, 3, 1};
    tbl[4]  = '{4000, 2000, 4, 1};
    tbl[5]  = '{507,  250, 1, 1};
    tbl[6]  = '{508,  250, 7, 1};
    tbl[7]  = '{493,  250, 1, 1};
    tbl[8]  = '{492,  250, 7, 1};
    tbl[9]  = '{4062, 2000, 4, 1};
    tbl[10] = '{4063, 2000, 7, 1};
    tbl[11] = '{1000, 100, 2, 1};
    tbl[12] = '{1000, 100, 2, 0};
    tbl[13] = '{1000, 900, 2, 0};
    tbl[14] = '{1000, 900, 2, 0};

    // Reset state
    reset  = 1'b1;
    sig_in = 1'b0;
    repeat (3) cyc();
    chk("reset_code",   rate_code, 0);
    chk("reset_period", period_cycles, 0);
    chk("reset_valid",  valid, 0);
    chk("reset_rchg",   rate_change, 0);
    chk("reset_nosig",  no_signal, 1);
    reset = 1'b0;
    cyc();

    // Table: each period's measurement appears at the start of the next one
    base = vtot;
    do_period(tbl[0].p, tbl[0].h);
    chk("arm_no_valid", vtot - base, 0);
    chk("arm_nosig", no_signal, 1);
    for (int i = 1; i <= 15; i++) begin
      base = vtot;
      if (i < 15) do_period(tbl[i].p, tbl[i].h);
      else        do_period(1000, 500);
      chk($sformatf("v%0d_count", i-1), vtot - base, 1);
      chk($sformatf("v%0d_code", i-1), last_code, tbl[i-1].code);
      chk($sformatf("v%0d_period", i-1), last_period, tbl[i-1].p);
      chk($sformatf("v%0d_rchg", i-1), last_rc, tbl[i-1].rc);
      if (i == 1) chk("v0_nosig", no_signal, 0);
    end

    // Timeout: last rise sampled at the first edge of the trailing period
    base   = vtot;
    sig_in = 1'b0;
    repeat (7002) cyc();
    chk("pre_timeout_nosig", no_signal, 0);
    chk("pre_timeout_code", rate_code, 2);
    cyc();
    chk("timeout_nosig", no_signal, 1);
    chk("timeout_code", rate_code, 0);
    chk("timeout_period", period_cycles, 0);
    chk("timeout_no_valid", vtot - base, 0);

    // Resume: first rise only arms
    base = vtot;
    do_period(1000, 500);
    chk("resume_arm_no_valid", vtot - base, 0);
    chk("resume_arm_nosig", no_signal, 1);

    // Second rise: update lands two edges after the sampling edge
    sig_in = 1'b1;
    cyc();
    chk("lat_edge_k", valid, 0);
    cyc();
    chk("lat_edge_k1", valid, 0);
    cyc();
    chk("lat_edge_k2_valid", valid, 1);
    chk("lat_edge_k2_period", period_cycles, 1000);
    chk("lat_edge_k2_code", rate_code, 2);
    chk("lat_edge_k2_rchg", rate_change, 1);
    chk("lat_edge_k2_nosig", no_signal, 0);
    cyc();
    chk("lat_edge_k3_valid", valid, 0);
    chk("lat_edge_k3_rchg", rate_change, 0);
    for (int c = 4; c < 1000; c++) begin
      sig_in = (c < 500);
      cyc();
    end

    // Lock at 500, then reset mid-period
    base = vtot;
    do_period(500, 250);
    chk("lock_a_count", vtot - base, 1);
    chk("lock_a_code", last_code, 2);
    chk("lock_a_rchg", last_rc, 0);
    do_period(500, 250);
    chk("lock_b_code", last_code, 1);
    chk("lock_b_rchg", last_rc, 1);
    for (int c = 0; c < 300; c++) begin
      sig_in = (c < 250);
      cyc();
    end
    chk("pre_reset_code", rate_code, 1);
    reset = 1'b1;
    #1;
    chk("midrst_code",   rate_code, 0);
    chk("midrst_period", period_cycles, 0);
    chk("midrst_valid",  valid, 0);
    chk("midrst_rchg",   rate_change, 0);
    chk("midrst_nosig",  no_signal, 1);
    cyc();
    reset = 1'b0;
    for (int c = 301; c < 500; c++) begin
      sig_in = 1'b0;
      cyc();
    end
    base = vtot;
    do_period(500, 250);
    chk("postrst_arm_no_valid", vtot - base, 0);
    chk("postrst_arm_nosig", no_signal, 1);
    base = vtot;
    do_period(500, 250);
    chk("postrst_count", vtot - base, 1);
    chk("postrst_code", last_code, 1);
    chk("postrst_period", last_period, 500);
    chk("postrst_rchg", last_rc, 1);

    chk("rchg_without_valid", spurious, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rate_detector.md
Name: rate_detector

Overview:
Receive-side companion to the board's slow-clock divider. Measures the period of a slow square-wave input in CLOCK_50 cycles and classifies it as 2 Hz, 1 Hz, 0.5 Hz, 0.25 Hz, unknown or absent. Used by the display/FSM logic to identify which tick rate is currently selected or routed. Checks divider output in-system.

Parameters:
CLK_HZ, 50000000, CLOCK_50 frequency in Hz; nominal periods and timeout derive from it (bench uses 1000).
TOL_DIV, 64, tolerance window = nominal/TOL_DIV cycles (integer divide), applied symmetrically.
CNT_W, 32, width of cycle counter and period_cycles.

Ports:
CLOCK_50  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
sig_in  in  1  slow square wave; asynchronous to CLOCK_50; assumed glitch-free; any duty cycle.
rate_code  out  3  classification: 0 NONE, 1 2Hz, 2 1Hz, 3 0.5Hz, 4 0.25Hz, 7 UNKNOWN.
period_cycles  out  CNT_W  last measured rise-to-rise period in CLOCK_50 cycles.
valid  out  1  one-cycle pulse when rate_code/period_cycles update from a measurement.
rate_change  out  1  one-cycle pulse, coincident with valid, when the new rate_code differs from the previous one.
no_signal  out  1  level; high when no rising edge has arrived for TIMEOUT cycles, or since reset.

Behaviour:
- Reset (async, active-high): rate_code=0, period_cycles=0, valid=0, rate_change=0, no_signal=1, FSM=WAIT_FIRST, counter=0, synchroniser flops=0.
- Input path: 2-FF synchroniser plus one previous-value flop. rise = sync2 & ~prev.
- Latency: sig_in high sampled at clock edge k. rise is asserted during cycle k+1 to k+2. Registered outputs update at edge k+2.
- Counter: on rise, cnt<=1; otherwise cnt<=cnt+1, saturating at TIMEOUT. With a clean period of P cycles, cnt==P on the cycle rise is asserted.
- Nominal periods: N1=CLK_HZ/2 (2Hz), N2=CLK_HZ (1Hz), N3=2*CLK_HZ (0.5Hz), N4=4*CLK_HZ (0.25Hz). TIMEOUT=8*CLK_HZ.
- Windows are inclusive: Ni-Ni/TOL_DIV <= cnt <= Ni+Ni/TOL_DIV maps to code i. Anything else maps to 7. Windows do not overlap for TOL_DIV>=4.
- FSM WAIT_FIRST: no valid output. On rise, go to MEASURE and set cnt=1. no_signal stays at its current value.
- FSM MEASURE, on rise:
  - period_cycles<=cnt; rate_code<=classify(cnt); valid<=1; no_signal<=0.
  - rate_change<=(classify(cnt)!=rate_code).
  - cnt<=1; stay in MEASURE.
- FSM MEASURE, when cnt==TIMEOUT and no rise:
  - no_signal<=1; rate_code<=0; period_cycles<=0; go to WAIT_FIRST.
  - No valid pulse. rate_change does not pulse.
- Simultaneous rise and cnt==TIMEOUT: rise wins. A measurement of TIMEOUT cycles is taken and classified 7.
- First rise after reset or timeout only arms the counter. The first valid arrives on the second rise.
- valid and rate_change are 0 in every cycle except as specified above.
- Reset mid-measurement: immediate clear to reset values. The partial count is discarded.
- Falling edges and duty cycle are ignored.

Decomposition:
- Package rate_pkg holds:
  - rate code constants RATE_NONE=0, RATE_2HZ=1, RATE_1HZ=2, RATE_05HZ=3, RATE_025HZ=4, RATE_UNKNOWN=7;
  - FSM state encoding WAIT_FIRST and MEASURE;
  - classify function taking cnt, CLK_HZ and TOL_DIV.
- Sub-module sync_rise_detect: 2-FF synchroniser plus rise pulse, async reset. Reusable for buttons and other slow inputs.
- The rate_detector top holds the counter, FSM, classifier and output registers.

Test Plan (CLK_HZ=1000, TOL_DIV=64; windows 493..507, 985..1015, 1969..2031, 3938..4062; TIMEOUT=8000):
1. Reset, then square wave with period 500 -> no valid on the 1st rise. On the 2nd rise: valid=1 for one cycle, period_cycles=500, rate_code=1, rate_change=1, no_signal=0. On the 3rd rise: valid=1, rate_change=0.
2. Periods 1000, 2000, 4000 in sequence -> rate_code 2, 3, 4; rate_change pulses at each switch; period_cycles equals the exact period. Also check that the update lands 2 edges after the sampled rise.
3. Boundary cases: period 507 -> code 1; 508 -> code 7; 493 -> 1; 492 -> 7; 4062 -> 4; 4063 -> 7.
4. Lock at 1000, then hold sig_in low -> 8000 cycles after the last rise: no_signal=1, rate_code=0, period_cycles=0, no valid. Resume at 1000 -> 1st rise gives no valid; 2nd rise gives valid, code 2.
5. Lock at 500, assert reset 300 cycles into a period -> all outputs return to reset values within the same cycle. After release, the next rise gives no valid.
6. Period 1000 with 10% duty, then 90% duty -> rate_code=2 throughout, period_cycles=1000, no spurious rate_change.
